flash_boot_copier: RTL and testbench
====================================

Name: flash_boot_copier

Overview:
Bus master that sits directly upstream of the flash bus slave. After a start pulse it reads a block of 32-bit words from flash through the slave's read/stall handshake and writes each word to SRAM over a second master port. It is used at boot to shadow the kernel/monitor image from flash into RAM before releasing the CPU, and reports busy/done/error to the boot sequencer.

Parameters:
SRC_BASE, 32'h0000_0000, flash word-aligned byte address of the first source word
DST_BASE, 32'h8000_0000, RAM word-aligned byte address of the first destination word
LEN_WORDS, 1024, number of 32-bit words to copy; 0 is legal
TIMEOUT, 255, max cycles to wait on any single bus transaction before error

Ports:
clk  in  1  single clock, also used by both attached slaves
rst_n  in  1  asynchronous reset, active low
start  in  1  single-cycle pulse; ignored while busy
busy  out  1  high from the cycle after an accepted start until done/error
done  out  1  sticky, high after a successful copy; cleared by start
error  out  1  sticky, high after a timeout; cleared by start
fl_read  out  1  flash read request
fl_address  out  32  flash byte address
fl_data_r  in  32  flash read data, valid when the stall falls
fl_stall  in  1  flash slave stall
ram_write  out  1  RAM write request
ram_address  out  32  RAM byte address
ram_data_w  out  32  RAM write data
ram_mask  out  4  byte mask, always 4'b0000 (full word; 0 = byte enabled)
ram_stall  in  1  RAM slave stall
copied  out  $clog2(LEN_WORDS+1)  words written so far

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy, done, error, fl_read, ram_write = 0; addresses = 0; copied = 0; data register = 0.
- Transaction handshake (both ports):
  - The master raises the request with a stable address/data.
  - It holds the request until it has sampled stall=1 and then stall=0.
  - The request drops in the cycle after stall is seen low.
  - Read data is captured on that falling-stall cycle.
  - stall=0 never seen high does not complete a transaction.
- FSM states: IDLE, FL_REQ, FL_WAIT, RAM_REQ, RAM_WAIT, DONE, ERROR.
- IDLE/DONE/ERROR + start: clear done, error and copied; load index = 0.
  - LEN_WORDS==0: go to DONE next cycle with busy pulsing for one cycle.
  - Otherwise go to FL_REQ.
- FL_REQ: fl_read=1, fl_address=SRC_BASE+4*index. Go to FL_WAIT when fl_stall=1.
- FL_WAIT: when fl_stall=0, latch fl_data_r, drop fl_read, go to RAM_REQ.
- RAM_REQ: ram_write=1, ram_address=DST_BASE+4*index, ram_data_w=latched word. Go to RAM_WAIT on ram_stall=1.
- RAM_WAIT: on ram_stall=0, drop ram_write and increment copied/index.
  - If index==LEN_WORDS-1: go to DONE (busy=0, done=1).
  - Otherwise go to FL_REQ.
- Timeout counter: 8+ bits, reset on each state entry, counts in FL_REQ/FL_WAIT/RAM_REQ/RAM_WAIT. Reaching TIMEOUT drops all requests and goes to ERROR (busy=0, error=1).
- fl_read and ram_write are never high in the same cycle.
- Address arithmetic is 32-bit modulo; wrap is not checked.
- Reset mid-copy aborts immediately. Requests drop asynchronously and nothing resumes.
- start while busy is ignored.

Optional Feature:
FLASH_BOOT_CHECKSUM_EN:
- When defined:
  - Adds output checksum[31:0] and input expected_sum[31:0].
  - checksum accumulates the 32-bit modulo sum of every word latched in FL_WAIT and is cleared on start.
  - On the final word: if checksum != expected_sum, go to ERROR instead of DONE.
- When undefined: neither port exists and completion always reaches DONE.

Decomposition:
- Package per_defs (existing) gains the BootCopyState enum, BOOT_TIMEOUT_W, and the full-word mask constant.
- Natural sub-module: bus_master_port. It owns one request/stall two-phase handshake plus its timeout counter, and is instantiated twice (flash read, RAM write).

Test Plan:
- LEN_WORDS=4, flash words 11111111..44444444, slaves stall 3 cycles -> RAM 0x80000000..0x8000000C hold those words, done=1, copied=4, busy low.
- LEN_WORDS=0, start pulse -> no fl_read/ram_write ever asserted, done=1 one cycle later.
- fl_stall held low forever after fl_read -> error=1 after TIMEOUT+1 cycles, fl_read=0, done=0.
- rst_n low at word 2 of 4 -> all outputs 0 immediately. A new start then copies from index 0 and completes with copied=4.
- start pulsed while busy -> ignored, final copied=LEN_WORDS. Then start again after done -> done clears and the copy repeats.
- CHECKSUM_EN, words 1,2,3,4 with expected_sum=10 -> done=1. With expected_sum=11 -> error=1, checksum=10.

Source files
------------

// File: rtl/flash_boot_copier_pkg.sv
// Shared types, widths and helpers for the flash-to-RAM boot copier.
package flash_boot_copier_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned MASK_W         = 4;
  localparam int unsigned BOOT_TIMEOUT_W = 16;

  // Mask bits are active-low byte enables, so all-zero writes the full word
  localparam logic [MASK_W-1:0] FULL_WORD_MASK = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FL_REQ,
    ST_FL_WAIT,
    ST_RAM_REQ,
    ST_RAM_WAIT,
    ST_DONE,
    ST_ERROR
  } boot_copy_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_REQ,
    PH_WAIT
  } port_phase_e;

  // A zero-length copy still needs a one-bit counter
  function automatic int unsigned copied_width(input int unsigned len);
    return (len == 0) ? 1 : $clog2(len + 1);
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/flash_boot_copier_if.sv
// Flash read port and RAM write port of the boot copier, grouped as one bus.
interface flash_boot_copier_if;
  import flash_boot_copier_pkg::*;

  logic              fl_read;
  logic [ADDR_W-1:0] fl_address;
  logic [DATA_W-1:0] fl_data_r;
  logic              fl_stall;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_w;
  logic [MASK_W-1:0] ram_mask;
  logic              ram_stall;

  modport master (
    output fl_read, fl_address, ram_write, ram_address, ram_data_w, ram_mask,
    input  fl_data_r, fl_stall, ram_stall
  );

  modport slave (
    input  fl_read, fl_address, ram_write, ram_address, ram_data_w, ram_mask,
    output fl_data_r, fl_stall, ram_stall
  );
endinterface

// File: rtl/flash_boot_copier_bus_master_port.sv
// One request/stall two-phase handshake: request held until stall is seen
// high then low, with a per-phase timeout counter.
module flash_boot_copier_bus_master_port
  import flash_boot_copier_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic launch,
  input  logic stall,
  output logic req,
  output logic advance_c,
  output logic complete_c,
  output logic timeout_c
);

  localparam logic [BOOT_TIMEOUT_W-1:0] LIMIT = BOOT_TIMEOUT_W'(TIMEOUT);

  port_phase_e               phase, phase_next;
  logic [BOOT_TIMEOUT_W-1:0] cnt, cnt_next;
  logic                      req_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH_IDLE;
      cnt   <= '0;
      req   <= 1'b0;
    end else begin
      phase <= phase_next;
      cnt   <= cnt_next;
      req   <= req_next;
    end
  end

  // Counter restarts on every phase entry; progress wins over a coinciding timeout
  always_comb begin
    phase_next = phase;
    cnt_next   = cnt;
    req_next   = req;
    advance_c  = 1'b0;
    complete_c = 1'b0;
    timeout_c  = 1'b0;
    unique case (phase)
      PH_IDLE: begin
        if (launch) begin
          phase_next = PH_REQ;
          cnt_next   = '0;
          req_next   = 1'b1;
        end
      end
      PH_REQ: begin
        if (stall) begin
          advance_c  = 1'b1;
          phase_next = PH_WAIT;
          cnt_next   = '0;
        end else if (cnt == LIMIT) begin
          timeout_c  = 1'b1;
          phase_next = PH_IDLE;
          req_next   = 1'b0;
        end else begin
          cnt_next = cnt + BOOT_TIMEOUT_W'(1);
        end
      end
      PH_WAIT: begin
        if (!stall) begin
          complete_c = 1'b1;
          phase_next = PH_IDLE;
          req_next   = 1'b0;
        end else if (cnt == LIMIT) begin
          timeout_c  = 1'b1;
          phase_next = PH_IDLE;
          req_next   = 1'b0;
        end else begin
          cnt_next = cnt + BOOT_TIMEOUT_W'(1);
        end
      end
      default: phase_next = PH_IDLE;
    endcase
  end

endmodule

// File: rtl/flash_boot_copier.sv
// Boot-time copier: shadows LEN_WORDS flash words into RAM, reporting busy/done/error.
// Optional FLASH_BOOT_CHECKSUM_EN adds a running word sum verified on the last word.
module flash_boot_copier
  import flash_boot_copier_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SRC_BASE  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] DST_BASE  = 32'h8000_0000,
  parameter int unsigned       LEN_WORDS = 1024,
  parameter int unsigned       TIMEOUT   = 255,
  localparam int unsigned      CW        = copied_width(LEN_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CW-1:0]     copied,
`ifdef FLASH_BOOT_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
  input  logic [DATA_W-1:0] expected_sum,
`endif
  flash_boot_copier_if.master bus
);

  localparam logic [CW-1:0] LAST = CW'(LEN_WORDS - 1);

  boot_copy_state_e  state, state_next;
  logic              busy_next, done_next, error_next, sum_ok;
  logic [CW-1:0]     copied_next;
  logic [ADDR_W-1:0] fl_addr_q, fl_addr_next, ram_addr_q, ram_addr_next;
  logic [DATA_W-1:0] data_q, data_next;
  logic              fl_launch, fl_adv, fl_cmp, fl_to;
  logic              ram_launch, ram_adv, ram_cmp, ram_to;
`ifdef FLASH_BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_next;
`endif

  flash_boot_copier_bus_master_port #(.TIMEOUT(TIMEOUT)) u_fl_port (
    .clk        (clk),
    .rst_n      (rst_n),
    .launch     (fl_launch),
    .stall      (bus.fl_stall),
    .req        (bus.fl_read),
    .advance_c  (fl_adv),
    .complete_c (fl_cmp),
    .timeout_c  (fl_to)
  );

  flash_boot_copier_bus_master_port #(.TIMEOUT(TIMEOUT)) u_ram_port (
    .clk        (clk),
    .rst_n      (rst_n),
    .launch     (ram_launch),
    .stall      (bus.ram_stall),
    .req        (bus.ram_write),
    .advance_c  (ram_adv),
    .complete_c (ram_cmp),
    .timeout_c  (ram_to)
  );

  assign bus.fl_address  = fl_addr_q;
  assign bus.ram_address = ram_addr_q;
  assign bus.ram_data_w  = data_q;
  assign bus.ram_mask    = FULL_WORD_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      copied     <= '0;
      fl_addr_q  <= '0;
      ram_addr_q <= '0;
      data_q     <= '0;
`ifdef FLASH_BOOT_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      state      <= state_next;
      busy       <= busy_next;
      done       <= done_next;
      error      <= error_next;
      copied     <= copied_next;
      fl_addr_q  <= fl_addr_next;
      ram_addr_q <= ram_addr_next;
      data_q     <= data_next;
`ifdef FLASH_BOOT_CHECKSUM_EN
      checksum   <= checksum_next;
`endif
    end
  end

`ifdef FLASH_BOOT_CHECKSUM_EN
  assign sum_ok = (checksum == expected_sum);
`else
  assign sum_ok = 1'b1;
`endif

  always_comb begin
    state_next    = state;
    busy_next     = busy;
    done_next     = done;
    error_next    = error;
    copied_next   = copied;
    fl_addr_next  = fl_addr_q;
    ram_addr_next = ram_addr_q;
    data_next     = data_q;
    fl_launch     = 1'b0;
    ram_launch    = 1'b0;
`ifdef FLASH_BOOT_CHECKSUM_EN
    checksum_next = checksum;
`endif
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        // A zero-length copy parks in DONE with busy set for one cycle, then settles
        if (state == ST_DONE) begin
          busy_next = 1'b0;
          done_next = 1'b1;
        end
        if (start && !busy) begin
          done_next   = 1'b0;
          error_next  = 1'b0;
          copied_next = '0;
          busy_next   = 1'b1;
`ifdef FLASH_BOOT_CHECKSUM_EN
          checksum_next = '0;
`endif
          if (LEN_WORDS == 0) begin
            state_next = ST_DONE;
          end else begin
            state_next   = ST_FL_REQ;
            fl_launch    = 1'b1;
            fl_addr_next = word_addr(SRC_BASE, '0);
          end
        end
      end
      ST_FL_REQ: if (fl_adv) state_next = ST_FL_WAIT;
      ST_FL_WAIT: begin
        if (fl_cmp) begin
          state_next    = ST_RAM_REQ;
          data_next     = bus.fl_data_r;
          ram_launch    = 1'b1;
          ram_addr_next = word_addr(DST_BASE, ADDR_W'(copied));
`ifdef FLASH_BOOT_CHECKSUM_EN
          checksum_next = checksum + bus.fl_data_r;
`endif
        end
      end
      ST_RAM_REQ: if (ram_adv) state_next = ST_RAM_WAIT;
      ST_RAM_WAIT: begin
        if (ram_cmp) begin
          copied_next = copied + CW'(1);
          if (copied == LAST) begin
            busy_next  = 1'b0;
            state_next = sum_ok ? ST_DONE : ST_ERROR;
            done_next  = sum_ok;
            error_next = !sum_ok;
          end else begin
            state_next   = ST_FL_REQ;
            fl_launch    = 1'b1;
            fl_addr_next = word_addr(SRC_BASE, ADDR_W'(copied) + ADDR_W'(1));
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Any stuck transaction aborts the copy; the port has already dropped its request
    if (fl_to || ram_to) begin
      state_next = ST_ERROR;
      busy_next  = 1'b0;
      error_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_flash_boot_copier.sv
// Bench for flash_boot_copier: stalling flash/RAM slave models and a RAM-write scoreboard.
module tb_flash_boot_copier;

  localparam int unsigned TMO   = 30;
  localparam int unsigned STALL = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start0;
  logic        busy, done, error;
  logic [2:0]  copied;
  logic        busy0, done0, error0;
  logic [0:0]  copied0;
`ifdef FLASH_BOOT_CHECKSUM_EN
  logic [31:0] checksum, expected_sum, checksum0;
  logic [31:0] expected_sum0 = '0;
`endif

  flash_boot_copier_if bus ();
  flash_boot_copier_if bus0 ();

  flash_boot_copier #(.LEN_WORDS(4), .TIMEOUT(TMO)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .copied       (copied),
`ifdef FLASH_BOOT_CHECKSUM_EN
    .checksum     (checksum),
    .expected_sum (expected_sum),
`endif
    .bus          (bus)
  );

  flash_boot_copier #(.LEN_WORDS(0)) u_dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start0),
    .busy         (busy0),
    .done         (done0),
    .error        (error0),
    .copied       (copied0),
`ifdef FLASH_BOOT_CHECKSUM_EN
    .checksum     (checksum0),
    .expected_sum (expected_sum0),
`endif
    .bus          (bus0)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] image[4];
  logic        fl_hang = 1'b0;
  logic        overlap_seen = 1'b0;
  logic        len0_req_seen = 1'b0;
  int          fl_phase = 0, fl_cnt = 0, ram_phase = 0, ram_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flash_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    return (idx < 4) ? image[idx[1:0]] : 32'hbad0_0000;
  endfunction

  // Flash slave: stall STALL cycles per read, present data as stall falls
  always @(negedge clk) begin
    if (!rst_n) begin
      fl_phase     = 0;
      bus.fl_stall  = 1'b0;
      bus.fl_data_r = 32'hdead_beef;
    end else begin
      case (fl_phase)
        0: if (bus.fl_read && !fl_hang) begin
          bus.fl_stall = 1'b1;
          fl_cnt       = STALL;
          fl_phase     = 1;
        end
        1: begin
          fl_cnt--;
          if (fl_cnt == 0) begin
            bus.fl_stall  = 1'b0;
            bus.fl_data_r = flash_word(bus.fl_address);
            fl_phase      = 2;
          end
        end
        default: begin
          bus.fl_data_r = 32'hdead_beef;
          fl_phase      = 0;
        end
      endcase
    end
  end

  // RAM slave: stall STALL cycles, score the write as stall falls
  always @(negedge clk) begin
    logic [63:0] exp;
    if (!rst_n) begin
      ram_phase     = 0;
      bus.ram_stall = 1'b0;
    end else begin
      case (ram_phase)
        0: if (bus.ram_write) begin
          bus.ram_stall = 1'b1;
          ram_cnt       = STALL;
          ram_phase     = 1;
        end
        1: begin
          ram_cnt--;
          if (ram_cnt == 0) begin
            bus.ram_stall = 1'b0;
            ram_phase     = 2;
            check_eq("ram_mask", 64'(bus.ram_mask), 64'd0);
            if (sb_q.size() == 0) begin
              check_eq("ram_extra_write", 64'(sb_q.size()), 64'd1);
            end else begin
              exp = sb_q.pop_front();
              check_eq("ram_addr", 64'(bus.ram_address), 64'(exp[63:32]));
              check_eq("ram_data", 64'(bus.ram_data_w), 64'(exp[31:0]));
            end
          end
        end
        default: ram_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (bus.fl_read && bus.ram_write) overlap_seen = 1'b1;
    if (bus0.fl_read || bus0.ram_write) len0_req_seen = 1'b1;
  end

  initial begin
    bus0.fl_stall  = 1'b0;
    bus0.fl_data_r = '0;
    bus0.ram_stall = 1'b0;
  end

  task automatic push_copy();
    for (int i = 0; i < 4; i++)
      sb_q.push_back({32'h8000_0000 + 32'(i) * 32'd4, image[i]});
`ifdef FLASH_BOOT_CHECKSUM_EN
    expected_sum = '0;
    for (int i = 0; i < 4; i++) expected_sum += image[i];
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    rst_n  = 1'b1;
    start  = 1'b0;
    start0 = 1'b0;
    image  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
`ifdef FLASH_BOOT_CHECKSUM_EN
    expected_sum = '0;
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_error", 64'(error), 64'd0);
    check_eq("rst_fl_read", 64'(bus.fl_read), 64'd0);
    check_eq("rst_ram_write", 64'(bus.ram_write), 64'd0);
    check_eq("rst_copied", 64'(copied), 64'd0);
    check_eq("rst_fl_addr", 64'(bus.fl_address), 64'd0);
    check_eq("rst_ram_addr", 64'(bus.ram_address), 64'd0);
    check_eq("rst_ram_data", 64'(bus.ram_data_w), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Basic four-word copy
    push_copy();
    pulse_start();
    check_eq("c1_busy_rise", 64'(busy), 64'd1);
    check_eq("c1_fl_read", 64'(bus.fl_read), 64'd1);
    check_eq("c1_fl_addr", 64'(bus.fl_address), 64'h0);
    wait_idle();
    check_eq("c1_done", 64'(done), 64'd1);
    check_eq("c1_error", 64'(error), 64'd0);
    check_eq("c1_copied", 64'(copied), 64'd4);
    check_eq("c1_sb_empty", 64'(sb_q.size()), 64'd0);

    // Zero-length copy
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    check_eq("z_busy_pulse", 64'(busy0), 64'd1);
    check_eq("z_done_early", 64'(done0), 64'd0);
    @(negedge clk);
    check_eq("z_busy_end", 64'(busy0), 64'd0);
    check_eq("z_done", 64'(done0), 64'd1);
    check_eq("z_error", 64'(error0), 64'd0);

    // Flash never stalls: the read must time out
    fl_hang = 1'b1;
    pulse_start();
    check_eq("to_done_clr", 64'(done), 64'd0);
    check_eq("to_fl_read", 64'(bus.fl_read), 64'd1);
    n = 0;
    while (!error && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("to_cycles", 64'(n), 64'(TMO + 1));
    check_eq("to_error", 64'(error), 64'd1);
    check_eq("to_fl_read_drop", 64'(bus.fl_read), 64'd0);
    check_eq("to_done", 64'(done), 64'd0);
    check_eq("to_busy", 64'(busy), 64'd0);
    fl_hang = 1'b0;

    // Reset in the middle of word 2, then a clean restart from index 0
    push_copy();
    pulse_start();
    check_eq("mr_error_clr", 64'(error), 64'd0);
    n = 0;
    while (copied != 3'd2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("mr_reached_w2", 64'(copied), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_busy", 64'(busy), 64'd0);
    check_eq("mr_fl_read", 64'(bus.fl_read), 64'd0);
    check_eq("mr_ram_write", 64'(bus.ram_write), 64'd0);
    check_eq("mr_copied", 64'(copied), 64'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_copy();
    pulse_start();
    wait_idle();
    check_eq("mr_done", 64'(done), 64'd1);
    check_eq("mr_copied_final", 64'(copied), 64'd4);
    check_eq("mr_sb_empty", 64'(sb_q.size()), 64'd0);

    // Start while busy is ignored; a later start repeats the copy
    push_copy();
    pulse_start();
    repeat (10) @(negedge clk);
    pulse_start();
    wait_idle();
    check_eq("sb_done", 64'(done), 64'd1);
    check_eq("sb_copied", 64'(copied), 64'd4);
    check_eq("sb_no_extra", 64'(sb_q.size()), 64'd0);
    push_copy();
    pulse_start();
    check_eq("rep_done_clr", 64'(done), 64'd0);
    check_eq("rep_busy", 64'(busy), 64'd1);
    wait_idle();
    check_eq("rep_done", 64'(done), 64'd1);
    check_eq("rep_copied", 64'(copied), 64'd4);

`ifdef FLASH_BOOT_CHECKSUM_EN
    image = '{32'd1, 32'd2, 32'd3, 32'd4};
    push_copy();
    pulse_start();
    wait_idle();
    check_eq("cs_ok_done", 64'(done), 64'd1);
    check_eq("cs_ok_error", 64'(error), 64'd0);
    check_eq("cs_ok_sum", 64'(checksum), 64'd10);
    push_copy();
    expected_sum = 32'd11;
    pulse_start();
    wait_idle();
    check_eq("cs_bad_error", 64'(error), 64'd1);
    check_eq("cs_bad_done", 64'(done), 64'd0);
    check_eq("cs_bad_sum", 64'(checksum), 64'd10);
`endif

    check_eq("no_overlap", 64'(overlap_seen), 64'd0);
    check_eq("len0_no_req", 64'(len0_req_seen), 64'd0);
    check_eq("sb_final_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
